joy_db15_responder: RTL
=======================

Name: joy_db15_responder

Overview:
- Emulates the DB15 adapter end of the UserIO serial joystick link: the parallel-load shift-register side that the joystick reader clocks.
- Captures two 12-bit button vectors when the reader asserts JOY_LOAD, then shifts them out on JOY_DATA, one bit per rising JOY_CLK.
- Used as a loopback or verification model, and for driving a MiSTer reader from a second board.
- All logic runs on clk; JOY_LOAD and JOY_CLK are asynchronous inputs.

Parameters:
- NBITS, 12, bits per player. Frame length is 2*NBITS.
- FILTER, 3, clk cycles a synchronised line must hold a new level before it is accepted (glitch filter, minimum 1).
- TIMEOUT, 4096, clk cycles without an accepted JOY_CLK rise in SHIFT before the frame is abandoned.

Ports:
- clk  in  1  system clock, 40-50 MHz
- reset_n  in  1  asynchronous active-low reset
- joy1_in  in  NBITS  player 1 buttons, active-high, bit order FEDCBAUDLR + L S (bit 0 = R)
- joy2_in  in  NBITS  player 2 buttons, same layout
- JOY_LOAD  in  1  from reader, active-low parallel load
- JOY_CLK  in  1  from reader, shift clock, rising edge shifts
- JOY_DATA  out  1  serial data to reader, active-low buttons
- frame_done  out  1  one-clk pulse after the last bit has been shifted
- active  out  1  high while in LOAD or SHIFT
- bit_idx  out  5  index of the bit currently on JOY_DATA; 0 in IDLE

Behaviour:
- Reset: all of the following until reset_n rises.
  - shift register all 1s; JOY_DATA=1; frame_done=0; active=0; bit_idx=0; state IDLE.
  - filtered JOY_LOAD and JOY_CLK levels preset to 1.
- Input conditioning:
  - Each line passes a 2-FF synchroniser, then a FILTER-cycle stability counter.
  - The filtered level updates only after FILTER consecutive equal samples that differ from the current filtered level.
  - Edge detect runs on the filtered levels.
  - Latency from pin change to accepted edge: 2+FILTER clk cycles.
- Frame format: frame = {~joy2_in, ~joy1_in} (inverted, because the line is active-low). First bit out is ~joy1_in[0]; last bit is ~joy2_in[NBITS-1].
- States:
  - IDLE: JOY_DATA=1. Filtered JOY_LOAD low → LOAD.
  - LOAD: every clk, shift register <= frame; JOY_DATA=frame[0]; bit_idx=0. Filtered JOY_LOAD high → SHIFT.
  - SHIFT: on an accepted JOY_CLK rise, shift right with 1 filling from the top; bit_idx+1; JOY_DATA shows the new bit 0 on the next clk.
    - The rise that moves bit_idx from 2*NBITS-1 to 2*NBITS → DONE. JOY_DATA=1 from then on.
  - DONE: frame_done=1 for exactly one clk, then IDLE.
- Priority and boundary rules:
  - JOY_LOAD low overrides everything. Filtered load falling in SHIFT or DONE → LOAD immediately; the partial frame is discarded and no frame_done is issued.
  - JOY_CLK rises while load is low are ignored.
  - Load rise and clk rise accepted on the same cycle: enter SHIFT, ignore that clock edge.
  - Timeout counter resets on entry to SHIFT and on each accepted JOY_CLK rise. Reaching TIMEOUT → IDLE with JOY_DATA=1 and no frame_done.
  - joy1_in and joy2_in are sampled every clk while in LOAD; only the value on the last LOAD cycle is shifted. Changes during SHIFT do not affect the frame.
  - Extra JOY_CLK rises in IDLE are ignored; JOY_DATA stays 1.
  - reset_n low mid-frame → immediate reset values, asynchronously.
- JOY_DATA, frame_done, active and bit_idx are registered outputs with no combinational path from the inputs.

Test Plan:
- Reset: reset_n=0 with toggling inputs → JOY_DATA=1, active=0, bit_idx=0, frame_done=0 throughout; on release, state is IDLE.
- Full frame: joy1_in=12'h021, joy2_in=12'h800, JOY_LOAD low 20 clk then high, 24 JOY_CLK pulses of 10 clk high/10 clk low → serial bits read before each rise = 0,1,1,1,1,0,1…1 for P1, then 1×11 and 0 last for P2; one frame_done pulse; JOY_DATA=1 afterwards.
- Glitch: 1-clk low pulse on JOY_LOAD, and a 2-clk JOY_CLK pulse with FILTER=3 → no state change, bit_idx unchanged.
- Reload mid-frame: after 7 shifts, JOY_LOAD low → bit_idx=0, JOY_DATA=~joy1_in[0] within 2+FILTER+1 clk; no frame_done.
- Timeout: load, 3 shifts, then no JOY_CLK for TIMEOUT clk → IDLE, JOY_DATA=1, active=0, no frame_done.
- Input change: joy1_in changed from 0 to 12'hFFF during SHIFT → remaining bits reflect the value latched in LOAD (all 1s on the line).

Source files
------------

// File: rtl/joy_db15_responder.sv
// DB15 adapter side of the UserIO serial joystick link: latches two button vectors
// on JOY_LOAD and shifts them out active-low, one bit per filtered JOY_CLK rise.

module joy_db15_filt #(
    parameter int FILTER = 3
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic lvl
);
    localparam int CW = (FILTER < 2) ? 1 : $clog2(FILTER);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;

    // Level moves only after FILTER consecutive samples disagree with it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync <= 2'b11;
            cnt  <= '0;
            lvl  <= 1'b1;
        end else begin
            sync <= {sync[0], din};
            if (sync[1] == lvl) begin
                cnt <= '0;
            end else if (cnt == CW'(FILTER - 1)) begin
                lvl <= sync[1];
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

module joy_db15_responder #(
    parameter int NBITS   = 12,
    parameter int FILTER  = 3,
    parameter int TIMEOUT = 4096
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [NBITS-1:0] joy1_in,
    input  logic [NBITS-1:0] joy2_in,
    input  logic             JOY_LOAD,
    input  logic             JOY_CLK,
    output logic             JOY_DATA,
    output logic             frame_done,
    output logic             active,
    output logic [4:0]       bit_idx
);
    localparam int FLEN = 2 * NBITS;
    localparam int TW   = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    logic [1:0]      pins, lvl;
    logic            clk_prev;
    state_t          state_q, state_n;
    logic [FLEN-1:0] sreg_q, sreg_n, frame;
    logic [4:0]      idx_q, idx_n;
    logic [TW-1:0]   tmo_q, tmo_n;
    logic            done_q, done_n, act_q;
    logic            load_lo, clk_rise;

    assign pins = {JOY_CLK, JOY_LOAD};

    genvar g;
    generate
        for (g = 0; g < 2; g++) begin : g_filt
            joy_db15_filt #(.FILTER(FILTER)) u_filt (
                .clk    (clk),
                .reset_n(reset_n),
                .din    (pins[g]),
                .lvl    (lvl[g])
            );
        end
    endgenerate

    assign frame    = {~joy2_in, ~joy1_in};
    assign load_lo  = ~lvl[0];
    assign clk_rise = lvl[1] & ~clk_prev;

    // The line is the LSB of the shift register; 1-fill makes it idle high after the frame.
    always_comb begin
        state_n = state_q;
        sreg_n  = sreg_q;
        idx_n   = idx_q;
        tmo_n   = tmo_q;
        done_n  = 1'b0;
        unique case (state_q)
            IDLE: begin
                sreg_n = '1;
                idx_n  = '0;
                if (load_lo) begin
                    state_n = LOAD;
                    sreg_n  = frame;
                end
            end
            LOAD: begin
                sreg_n = frame;
                idx_n  = '0;
                tmo_n  = '0;
                if (!load_lo) state_n = SHIFT;
            end
            SHIFT: begin
                if (load_lo) begin
                    state_n = LOAD;
                    sreg_n  = frame;
                    idx_n   = '0;
                end else if (clk_rise) begin
                    sreg_n = {1'b1, sreg_q[FLEN-1:1]};
                    idx_n  = idx_q + 1'b1;
                    tmo_n  = '0;
                    if (idx_q == 5'(FLEN - 1)) begin
                        state_n = DONE;
                        sreg_n  = '1;
                        done_n  = 1'b1;
                    end
                end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    state_n = IDLE;
                    sreg_n  = '1;
                    idx_n   = '0;
                end else begin
                    tmo_n = tmo_q + 1'b1;
                end
            end
            DONE: begin
                if (load_lo) begin
                    state_n = LOAD;
                    sreg_n  = frame;
                end else begin
                    state_n = IDLE;
                    sreg_n  = '1;
                end
                idx_n = '0;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            sreg_q   <= '1;
            idx_q    <= '0;
            tmo_q    <= '0;
            done_q   <= 1'b0;
            act_q    <= 1'b0;
            clk_prev <= 1'b1;
        end else begin
            state_q  <= state_n;
            sreg_q   <= sreg_n;
            idx_q    <= idx_n;
            tmo_q    <= tmo_n;
            done_q   <= done_n;
            act_q    <= (state_n == LOAD) || (state_n == SHIFT);
            clk_prev <= lvl[1];
        end
    end

    assign JOY_DATA   = sreg_q[0];
    assign frame_done = done_q;
    assign active     = act_q;
    assign bit_idx    = idx_q;
endmodule
